// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-PC sequencer: address width, FSM encoding
// and the default reset PC.
package pc_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam logic [InstAddrBus-1:0] ResetPc = 32'h0000_0000;

    typedef enum logic [1:0] {
        PcCtrlBoot     = 2'b00,
        PcCtrlRun      = 2'b01,
        PcCtrlRedirect = 2'b10
    } pc_state_e;

    // Fetch addresses are always word aligned.
    function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] a);
        return {a[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_ctrl_sat_cnt.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module pc_ctrl_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-PC sequencer: owns the fetch PC, follows the branch predictor, redirects
// on EX mispredicts, and drives predictor training plus performance counters.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = ResetPc,
    parameter int                     CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_stall_i,
    output logic                   if_pc_valid_o,
    output logic [InstAddrBus-1:0] if_pc_o,
    output logic                   if_pred_taken_o,
    output logic [InstAddrBus-1:0] if_pred_npc_o,
    output logic [InstAddrBus-1:0] bp_pc_o,
    input  logic [InstAddrBus-1:0] bp_npc_i,
    input  logic                   bp_taken_i,
    input  logic                   ex_valid_i,
    input  logic                   ex_is_branch_i,
    input  logic [InstAddrBus-1:0] ex_pc_i,
    input  logic [InstAddrBus-1:0] ex_pred_npc_i,
    input  logic [InstAddrBus-1:0] ex_actual_npc_i,
    input  logic                   ex_taken_i,
    output logic                   flush_o,
    output logic                   bp_update_o,
    output logic [InstAddrBus-1:0] bp_branch_pc_o,
    output logic [InstAddrBus-1:0] bp_branch_npc_o,
    output logic                   bp_actual_result_o,
    output logic [CNT_W-1:0]       branch_cnt_o,
    output logic [CNT_W-1:0]       mispredict_cnt_o
);

    pc_state_e              state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic                   upd_q, upd_d;
    logic [InstAddrBus-1:0] upd_pc_q, upd_pc_d;
    logic [InstAddrBus-1:0] upd_npc_q, upd_npc_d;
    logic                   upd_res_q, upd_res_d;
    logic                   resolve, mispredict;

    // EX is on the wrong path while we are redirecting, so it is ignored then.
    assign resolve    = ex_valid_i && ex_is_branch_i && (state_q != PcCtrlRedirect);
    assign mispredict = resolve && (ex_actual_npc_i != ex_pred_npc_i);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        upd_d     = resolve;
        upd_pc_d  = upd_pc_q;
        upd_npc_d = upd_npc_q;
        upd_res_d = upd_res_q;

        unique case (state_q)
            PcCtrlBoot:     state_d = PcCtrlRun;
            PcCtrlRun:      if (!if_stall_i) pc_d = bp_npc_i;
            PcCtrlRedirect: state_d = PcCtrlRun;
            default:        state_d = PcCtrlBoot;
        endcase

        // Redirect wins over stall and over the predicted advance.
        if (mispredict) begin
            pc_d    = align_pc(ex_actual_npc_i);
            state_d = PcCtrlRedirect;
        end

        if (resolve) begin
            upd_pc_d  = ex_pc_i;
            upd_npc_d = ex_actual_npc_i;
            upd_res_d = ex_taken_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PcCtrlBoot;
            pc_q      <= RESET_PC;
            upd_q     <= 1'b0;
            upd_pc_q  <= '0;
            upd_npc_q <= '0;
            upd_res_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            upd_q     <= upd_d;
            upd_pc_q  <= upd_pc_d;
            upd_npc_q <= upd_npc_d;
            upd_res_q <= upd_res_d;
        end
    end

    pc_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolve),
        .cnt_o (branch_cnt_o)
    );

    pc_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict),
        .cnt_o (mispredict_cnt_o)
    );

    assign if_pc_o            = pc_q;
    assign bp_pc_o            = pc_q;
    assign if_pred_taken_o    = bp_taken_i;
    assign if_pred_npc_o      = bp_npc_i;
    assign if_pc_valid_o      = (state_q == PcCtrlRun);
    assign flush_o            = (state_q == PcCtrlRedirect);
    assign bp_update_o        = upd_q;
    assign bp_branch_pc_o     = upd_pc_q;
    assign bp_branch_npc_o    = upd_npc_q;
    assign bp_actual_result_o = upd_res_q;

endmodule
